csr_trap_seq: RTL



---
 rtl/csr_trap_seq_pkg.sv | 47 ++++
 rtl/csr_trap_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/csr_trap_seq_pkg.sv
// Shared constants for the trap sequencer: CSR addresses,
// instruction encodings, cause codes, states, mstatus helpers.
package csr_trap_seq_pkg;

    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        W_MEPC      = 3'd1,
        W_MSTATUS   = 3'd2,
        W_MCAUSE    = 3'd3,
        RET_MSTATUS = 3'd4,
        ASSERT      = 3'd5
    } state_t;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [31:0] trap_mstatus(
        input logic [31:0] ms
    );
        logic [31:0] r;
        r    = ms;
        r[7] = ms[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] ret_mstatus(
        input logic [31:0] ms
    );
        logic [31:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_seq.sv
// Trap sequencer driving the CSR file's secondary write port.
// Ports: ex-stage inst/pc/jump, irq vector + MIE, CSR reads in;
// hold, CSR we/waddr/data and fetch redirect (assert/addr) out.
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter logic [31:0] INT_CAUSE = 32'h8000_0004,
    parameter int          INT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic             global_int_en_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             hold_flag_o,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      data_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    state_t      state;
    logic [31:0] cause;

    logic        idle;
    logic        is_ecall;
    logic        is_sync;
    logic        is_mret;
    logic        is_async;
    logic [31:0] sync_epc;
    logic [31:0] async_epc;

    always_comb begin
        idle      = (state == IDLE);
        is_ecall  = (inst_i == INST_ECALL);
        is_sync   = idle && (is_ecall || inst_i == INST_EBREAK);
        is_mret   = idle && (inst_i == INST_MRET);
        is_async  = idle && (|int_flag_i) && global_int_en_i;
        sync_epc  = inst_addr_i + 32'd4;
        // a taken jump in ex means the interrupted flow resumes at its target
        async_epc = jump_flag_i ? jump_addr_i : inst_addr_i;
    end

    assign hold_flag_o = rst &&
        (!idle || is_sync || is_mret || is_async);

    // Outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cause        <= '0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
        end else begin
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            unique case (state)
                IDLE: begin
                    if (is_sync) begin
                        state   <= W_MEPC;
                        cause   <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        we_o    <= 1'b1;
                        waddr_o <= CSR_MEPC;
                        data_o  <= sync_epc;
                    end else if (is_mret) begin
                        state   <= RET_MSTATUS;
                        we_o    <= 1'b1;
                        waddr_o <= CSR_MSTATUS;
                        data_o  <= ret_mstatus(csr_mstatus_i);
                    end else if (is_async) begin
                        state   <= W_MEPC;
                        cause   <= INT_CAUSE;
                        we_o    <= 1'b1;
                        waddr_o <= CSR_MEPC;
                        data_o  <= async_epc;
                    end
                end
                W_MEPC: begin
                    state   <= W_MSTATUS;
                    we_o    <= 1'b1;
                    waddr_o <= CSR_MSTATUS;
                    data_o  <= trap_mstatus(csr_mstatus_i);
                end
                W_MSTATUS: begin
                    state   <= W_MCAUSE;
                    we_o    <= 1'b1;
                    waddr_o <= CSR_MCAUSE;
                    data_o  <= cause;
                end
                W_MCAUSE: begin
                    state        <= ASSERT;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mtvec_i;
                end
                RET_MSTATUS: begin
                    state        <= ASSERT;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mepc_i;
                end
                ASSERT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
